// File: rtl/JZJCoreFTypes.sv
// Shared types and helpers for the JZJCoreF integer register file.
package JZJCoreFTypes;

    typedef logic [4:0] RegAddress_t;

    localparam RegAddress_t X0_ADDRESS = 5'd0;

    // Number of architectural registers: RV32I has 32, RV32E has 16.
    function automatic int regCount(input bit rv32i);
        return rv32i ? 32 : 16;
    endfunction

    // RV32E ignores address bit 4, so x17 aliases x1 and so on.
    function automatic RegAddress_t effectiveAddress(input RegAddress_t address, input bit rv32i);
        return {address[4] & rv32i, address[3:0]};
    endfunction

endpackage

// File: rtl/register_scoreboard.sv
// Pending-load scoreboard: one bit per register, set on load issue, cleared on writeback.
module register_scoreboard
    import JZJCoreFTypes::*;
#(
    parameter int READ_PORTS = 2,
    parameter int RV32I      = 1,
    parameter int BYPASS     = 1
) (
    input  logic                    clock_i,
    input  logic                    resetN_i,
    input  logic                    allocEnable_i,
    input  RegAddress_t             allocAddress_i,
    input  logic                    clearEnable_i,
    input  RegAddress_t             clearAddress_i,
    input  logic [READ_PORTS*5-1:0] readAddress_i,
    output logic [READ_PORTS-1:0]   readPending_o,
    output logic                    anyPending_o
);

    localparam bit IS_RV32I = (RV32I != 0);
    localparam int NUM_REGS = regCount(IS_RV32I);

    RegAddress_t allocIdx;
    RegAddress_t clearIdx;
    logic        allocValid;
    logic        clearValid;

    logic [NUM_REGS-1:1] pending_q;
    logic [NUM_REGS-1:1] pending_d;

    assign allocIdx   = effectiveAddress(allocAddress_i, IS_RV32I);
    assign clearIdx   = effectiveAddress(clearAddress_i, IS_RV32I);
    assign allocValid = allocEnable_i && (allocIdx != X0_ADDRESS);
    assign clearValid = clearEnable_i && (clearIdx != X0_ADDRESS);

    // Next pending bits: a new load issue beats a writeback clearing the same register.
    always_comb begin
        for (int r = 1; r < NUM_REGS; r++) begin
            pending_d[r] = pending_q[r];
            if (allocValid && (allocIdx == RegAddress_t'(r))) begin
                pending_d[r] = 1'b1;
            end else if (clearValid && (clearIdx == RegAddress_t'(r))) begin
                pending_d[r] = 1'b0;
            end
        end
    end

    // Pending bit storage, cleared by the asynchronous reset.
    always_ff @(posedge clock_i or negedge resetN_i) begin
        if (!resetN_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign anyPending_o = |pending_q;

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_lookup
        RegAddress_t readIdx;
        logic        storedPending;
        logic        clearedNow;

        assign readIdx = effectiveAddress(readAddress_i[5*p +: 5], IS_RV32I);

        // Flat lookup of the stored pending bit; x0 is never pending.
        always_comb begin
            storedPending = 1'b0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (readIdx == RegAddress_t'(r)) begin
                    storedPending = pending_q[r];
                end
            end
        end

        assign clearedNow = (BYPASS != 0) && clearValid && (clearIdx == readIdx)
                            && !(allocValid && (allocIdx == readIdx));

        assign readPending_o[p] = storedPending && !clearedNow;
    end

endmodule

// File: rtl/multiport_register_file.sv
// Integer register file with early/late write ports, optional bypass and a load scoreboard.
module multiport_register_file
    import JZJCoreFTypes::*;
#(
    parameter int XLEN       = 32,
    parameter int RV32I      = 1,
    parameter int READ_PORTS = 2,
    parameter int BYPASS     = 1,
    parameter int DEBUG_REG  = 31
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [READ_PORTS*5-1:0]      rsAddress,
    output logic [READ_PORTS*XLEN-1:0]   rsData,
    output logic [READ_PORTS-1:0]        rsPending,
    input  logic                         wrEarlyEnable,
    input  logic [4:0]                   wrEarlyAddress,
    input  logic [XLEN-1:0]              wrEarlyData,
    input  logic                         wrLateEnable,
    input  logic [4:0]                   wrLateAddress,
    input  logic [XLEN-1:0]              wrLateData,
    input  logic                         allocEnable,
    input  logic [4:0]                   allocAddress,
    output logic                         anyPending,
    output logic [XLEN-1:0]              debugOutput
);

    localparam bit IS_RV32I    = (RV32I != 0);
    localparam int NUM_REGS    = regCount(IS_RV32I);
    localparam int DEBUG_INDEX = IS_RV32I ? DEBUG_REG : (DEBUG_REG % 16);

    RegAddress_t earlyIdx;
    RegAddress_t lateIdx;
    logic        earlyValid;
    logic        lateValid;

    logic [XLEN-1:0] regFile_q [1:NUM_REGS-1];
    logic [XLEN-1:0] regFile_d [1:NUM_REGS-1];

    assign earlyIdx   = effectiveAddress(wrEarlyAddress, IS_RV32I);
    assign lateIdx    = effectiveAddress(wrLateAddress, IS_RV32I);
    assign earlyValid = wrEarlyEnable && (earlyIdx != X0_ADDRESS);
    assign lateValid  = wrLateEnable && (lateIdx != X0_ADDRESS);

    // Next register values: the early ALU port wins over the late load port on a collision.
    always_comb begin
        for (int r = 1; r < NUM_REGS; r++) begin
            regFile_d[r] = regFile_q[r];
            if (earlyValid && (earlyIdx == RegAddress_t'(r))) begin
                regFile_d[r] = wrEarlyData;
            end else if (lateValid && (lateIdx == RegAddress_t'(r))) begin
                regFile_d[r] = wrLateData;
            end
        end
    end

    // Register storage x1..x(N-1); x0 is hardwired and never stored.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                regFile_q[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                regFile_q[r] <= regFile_d[r];
            end
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
        RegAddress_t     readIdx;
        logic [XLEN-1:0] storedValue;
        logic [XLEN-1:0] readValue;

        assign readIdx = effectiveAddress(rsAddress[5*p +: 5], IS_RV32I);

        // Flat one-level mux over every stored register.
        always_comb begin
            storedValue = '0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (readIdx == RegAddress_t'(r)) begin
                    storedValue = regFile_q[r];
                end
            end
        end

        // Forward same-cycle write data; held off during reset so reads stay zero.
        always_comb begin
            readValue = storedValue;
            if (readIdx == X0_ADDRESS) begin
                readValue = '0;
            end else if ((BYPASS != 0) && reset && earlyValid && (earlyIdx == readIdx)) begin
                readValue = wrEarlyData;
            end else if ((BYPASS != 0) && reset && lateValid && (lateIdx == readIdx)) begin
                readValue = wrLateData;
            end
        end

        assign rsData[XLEN*p +: XLEN] = readValue;
    end

    if (DEBUG_INDEX == 0) begin : g_debugZero
        assign debugOutput = '0;
    end else begin : g_debugReg
        assign debugOutput = regFile_q[DEBUG_INDEX];
    end

    register_scoreboard #(
        .READ_PORTS (READ_PORTS),
        .RV32I      (RV32I),
        .BYPASS     (BYPASS)
    ) u_scoreboard (
        .clock_i        (clock),
        .resetN_i       (reset),
        .allocEnable_i  (allocEnable),
        .allocAddress_i (allocAddress),
        .clearEnable_i  (wrLateEnable),
        .clearAddress_i (wrLateAddress),
        .readAddress_i  (rsAddress),
        .readPending_o  (rsPending),
        .anyPending_o   (anyPending)
    );

endmodule
